// File: rtl/trace_collector.sv
// Trace record collector: buffers strobed trace records in a FIFO and streams each one out LS word first.
// Optional feature: define TRACE_COLLECTOR_TIMESTAMP_EN to prefix every record with a 32-bit push-time stamp word.
module trace_collector #(
  parameter int TRACE_WIDTH = 96,
  parameter int OUT_WIDTH   = 32,
  parameter int DEPTH       = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     trace_ready_i,
  input  logic [TRACE_WIDTH-1:0]   trace_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OUT_WIDTH-1:0]     out_data_o,
  output logic                     out_last_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_count_o,
  input  logic                     clear_i
);

  localparam int WORDS = (TRACE_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
  localparam int TS_WORDS = 1;
`else
  localparam int TS_WORDS = 0;
`endif
  localparam int TOTAL_WORDS = WORDS + TS_WORDS;
  localparam int REC_W       = TOTAL_WORDS * OUT_WIDTH;
  localparam int PW          = $clog2(DEPTH);
  localparam int CW          = PW + 1;
  localparam int IW          = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL_WORDS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  logic             r_valid;
  logic             r_last;
  logic [IW-1:0]    r_idx;
  logic             r_overflow;
  logic [15:0]      r_drop_count;

  logic [REC_W-1:0] w_wr_rec;
  logic [REC_W-1:0] w_rd_rec;
  logic             w_handshake;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_next;
  logic [IW-1:0]    w_idx_inc;

`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
  logic [31:0]      r_cycle;

  // Free-running cycle stamp captured alongside each pushed record
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end
`endif

  // Record image as it will be streamed: optional stamp in word 0, data zero-padded above
  always_comb begin
    w_wr_rec = '0;
    w_wr_rec[TS_WORDS*OUT_WIDTH +: TRACE_WIDTH] = trace_i;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
    w_wr_rec[31:0] = r_cycle;
`endif
  end

  assign w_rd_rec     = r_mem[r_rd_ptr];
  assign w_handshake  = r_valid & out_ready_i;
  assign w_pop        = w_handshake & r_last;
  // A full FIFO still accepts a strobe if the head record leaves on the same edge
  assign w_push       = trace_ready_i & ((r_count != FULL_CNT) | w_pop);
  assign w_drop       = trace_ready_i & ~w_push;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_idx_inc    = r_idx + IW'(1);

  // Record storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_rec;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Stream FSM; looks at next occupancy so a strobe into an empty FIFO is visible one cycle later
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (w_count_next != '0) begin
            r_state <= ST_SEND;
            r_valid <= 1'b1;
            r_last  <= (LAST_IDX == '0);
          end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (w_handshake && r_last) begin
            r_idx <= '0;
            if (w_count_next != '0) begin
              r_valid <= 1'b1;
              r_last  <= (LAST_IDX == '0);
            end else begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end
          end else if (w_handshake) begin
            r_idx  <= w_idx_inc;
            r_last <= (w_idx_inc == LAST_IDX);
          end else begin
            r_idx <= r_idx;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Drop tracking; a drop in the same cycle as clear leaves exactly one drop recorded
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_i) begin
        r_drop_count <= 16'd1;
      end else if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end else begin
        r_drop_count <= r_drop_count;
      end
    end else if (clear_i) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 16'd0;
    end else begin
      r_overflow   <= r_overflow;
      r_drop_count <= r_drop_count;
    end
  end

  assign out_valid_o  = r_valid;
  assign out_last_o   = r_last;
  assign out_data_o   = r_valid ? w_rd_rec[int'(r_idx)*OUT_WIDTH +: OUT_WIDTH] : '0;
  assign fifo_count_o = r_count;
  assign overflow_o   = r_overflow;
  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_trace_collector.sv
// Randomized self-checking bench for trace_collector against a queue-based record model.
module tb_trace_collector;

  localparam int TW    = 96;
  localparam int OW    = 32;
  localparam int D     = 8;
  localparam int WORDS = 3;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
  localparam int TSW = 1;
`else
  localparam int TSW = 0;
`endif
  localparam int TOT = WORDS + TSW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          trace_ready_i;
  logic [TW-1:0] trace_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [OW-1:0] out_data_o;
  logic          out_last_o;
  logic [3:0]    fifo_count_o;
  logic          overflow_o;
  logic [15:0]   drop_count_o;
  logic          clear_i;

  trace_collector #(.TRACE_WIDTH(TW), .OUT_WIDTH(OW), .DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trace_ready_i(trace_ready_i), .trace_i(trace_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .fifo_count_o(fifo_count_o), .overflow_o(overflow_o),
    .drop_count_o(drop_count_o), .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [TW-1:0] d;
    logic [31:0]   ts;
  } rec_t;

  rec_t        q[$];
  int          widx;
  bit          m_ovf;
  int          m_dc;
  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] exp_word(input rec_t r, input int k);
    logic [WORDS*OW-1:0] p;
    p = '0;
    p[TW-1:0] = r.d;
    if (k < TSW) return r.ts;
    return p[(k-TSW)*OW +: OW];
  endfunction

  function automatic logic [TW-1:0] rand_rec();
    logic [TW-1:0] v;
    v = {$urandom, $urandom, $urandom};
    return v;
  endfunction

  task automatic check_outputs();
    check_eq("valid", out_valid_o, q.size() > 0);
    check_eq("last", out_last_o, (q.size() > 0) && (widx == TOT - 1));
    if (q.size() > 0) check_eq("data", out_data_o, exp_word(q[0], widx));
    check_eq("count", fifo_count_o, q.size());
    check_eq("overflow", overflow_o, m_ovf);
    check_eq("drop_count", drop_count_o, m_dc);
  endtask

  // One clock: check present outputs, apply inputs, advance the model, clock.
  task automatic step(input bit rdy, input bit stb, input logic [TW-1:0] d, input bit clr);
    bit   full, pop;
    rec_t r;
    check_outputs();
    out_ready_i = rdy; trace_ready_i = stb; trace_i = d; clear_i = clr;
    full = (q.size() == D);
    pop  = 1'b0;
    if (q.size() > 0 && rdy) begin
      if (widx == TOT - 1) begin
        pop = 1'b1;
        void'(q.pop_front());
        widx = 0;
      end else begin
        widx++;
      end
    end
    if (stb && (!full || pop)) begin
      r.d = d; r.ts = cyc;
      q.push_back(r);
    end else if (stb) begin
      m_ovf = 1'b1;
      m_dc  = clr ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
    end else if (clr) begin
      m_ovf = 1'b0; m_dc = 0;
    end
    if (clr && !(stb && full && !pop)) begin
      m_ovf = 1'b0; m_dc = 0;
    end
    @(posedge clk_i); cyc++;
    @(negedge clk_i);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) step(1'b1, 1'b0, '0, 1'b0);
    check_eq("drained", fifo_count_o, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; trace_ready_i = 1'b0; out_ready_i = 1'b0; clear_i = 1'b0;
    #1;
    check_eq("rst_valid", out_valid_o, 0);
    check_eq("rst_last", out_last_o, 0);
    check_eq("rst_data", out_data_o, 0);
    check_eq("rst_count", fifo_count_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    check_eq("rst_dc", drop_count_o, 0);
    q.delete(); widx = 0; m_ovf = 1'b0; m_dc = 0; cyc = 0;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; trace_ready_i = 1'b0; trace_i = '0; out_ready_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Single record, consumer always ready
    step(1'b1, 1'b1, 96'h0000000C_0000000B_0000000A, 1'b0);
`ifndef TRACE_COLLECTOR_TIMESTAMP_EN
    check_eq("t1_w0", out_data_o, 32'hA);
    step(1'b1, 1'b0, '0, 1'b0);
    check_eq("t1_w1", out_data_o, 32'hB);
    check_eq("t1_l1", out_last_o, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check_eq("t1_w2", out_data_o, 32'hC);
    check_eq("t1_l2", out_last_o, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    check_eq("t1_idle", out_valid_o, 1'b0);
`endif
    drain();

    // Back-pressure mid-record
    step(1'b0, 1'b1, rand_rec(), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0);
    drain();

    // Overflow, clear, drain
    for (int i = 0; i < D + 3; i++) step(1'b0, 1'b1, rand_rec(), 1'b0);
    check_eq("t3_count", fifo_count_o, D);
    check_eq("t3_ovf", overflow_o, 1'b1);
    check_eq("t3_dc", drop_count_o, 16'd3);
    step(1'b0, 1'b0, '0, 1'b1);
    check_eq("t3_ovf_clr", overflow_o, 1'b0);
    check_eq("t3_dc_clr", drop_count_o, 16'd0);

    // Full FIFO: strobe coincident with last-word handshake
    for (int i = 0; i < TOT - 1; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, rand_rec(), 1'b0);
    check_eq("t4_dc", drop_count_o, 16'd0);
    check_eq("t4_count", fifo_count_o, D);
    // Drop coincident with clear
    step(1'b0, 1'b1, rand_rec(), 1'b1);
    check_eq("t4_dc_clr_drop", drop_count_o, 16'd1);
    drain();

    // Reset mid-record, then a clean record
    step(1'b0, 1'b1, rand_rec(), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    do_reset();
    step(1'b1, 1'b1, rand_rec(), 1'b0);
    drain();

    // Timestamp spacing: strobes four cycles apart
    for (int i = 0; i < 4; i++) step(1'b0, (i == 0), rand_rec(), 1'b0);
    step(1'b0, 1'b1, rand_rec(), 1'b0);
    drain();

    // Random traffic with varying back-pressure bias
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 5) > ph, $urandom_range(0, 1) == 1, rand_rec(),
             $urandom_range(0, 15) == 0);
      end
    end
    drain();
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
